dso_capture_ctrl: RTL and testbench



---
 rtl/dso_capture_ctrl.sv | 146 ++++++++++++++
 tb/tb_dso_capture_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dso_capture_ctrl.sv
// Capture controller for the DSO acquisition path: decimates the ADC strobe, writes a
// circular pre/post-trigger trace into NCH channel RAMs and flags completion to readout.
module dso_capture_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DEC_W   = 4,
  parameter int NCH     = 3,
  parameter int AUTO_TO = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              smpl_tick,
  input  logic              run,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [DEC_W-1:0]  decimator,
  input  logic [NCH-1:0]    ch_en,
  input  logic              triggered,
  input  logic              clr_capture_done,
  output logic [NCH-1:0]    we,
  output logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              trig_en,
  output logic              armed,
  output logic              auto_trig,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trace_end,
  output logic              busy
);

  localparam int DCW = (1 << DEC_W) - 1;
  localparam int AW  = $clog2(AUTO_TO + 1);
  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [AW-1:0]   AUTO_LIM = AW'(AUTO_TO);
  localparam logic [1:0]      M_STOP   = 2'b00;
  localparam logic [1:0]      M_NORM   = 2'b01;
  localparam logic [1:0]      M_AUTO   = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [DCW-1:0]    dec_cnt;
  logic [DCW-1:0]    dec_last;
  logic [ADDR_W-1:0] smpl_cnt;
  logic [ADDR_W-1:0] trig_cnt;
  logic [AW-1:0]     auto_cnt;
  logic [ADDR_W-1:0] tp_eff;
  logic              keep, active, stop_req, wr;
  logic              pre_full, auto_hit, post_hit, auto_fire, done_set, start;

  // Terminal count of the decimator is 2^decimator-1, built without a wider shift.
  assign dec_last = ~({DCW{1'b1}} << decimator);
  assign keep     = smpl_tick && (dec_cnt == dec_last);

  assign active   = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign stop_req = !run || (mode == M_STOP);
  // An abort suppresses the write in the very cycle it is requested.
  assign wr       = active && !stop_req && keep;

  assign en      = wr;
  assign we      = wr ? ch_en : '0;
  assign trig_en = (state == S_ARMED);
  assign busy    = active;

  assign tp_eff   = (trig_pos == '0) ? ADDR_W'(1) : trig_pos;
  assign pre_full = ({1'b0, smpl_cnt} + (ADDR_W+1)'(wr) + {1'b0, tp_eff}) >= DEPTH;
  assign auto_hit = wr && (mode == M_AUTO) && ((auto_cnt + AW'(1)) == AUTO_LIM);
  assign post_hit = wr && (({1'b0, trig_cnt} + (ADDR_W+1)'(1)) >= {1'b0, tp_eff});

  // NOTE: every signal written here gets its default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    auto_fire = 1'b0;
    case (state)
      S_IDLE:
        if (!stop_req) begin
          state_nxt = S_PRE;
          start     = 1'b1;
        end
      S_PRE:
        if (stop_req)      state_nxt = S_IDLE;
        else if (pre_full) state_nxt = S_ARMED;
      S_ARMED:
        if (stop_req) state_nxt = S_IDLE;
        else if (triggered) state_nxt = S_POST;
        else if (auto_hit) begin
          state_nxt = S_POST;
          auto_fire = 1'b1;
        end
      S_POST:
        if (stop_req)      state_nxt = S_IDLE;
        else if (post_hit) state_nxt = S_DONE;
      S_DONE:
        if (stop_req) state_nxt = S_IDLE;
        else if (clr_capture_done && (mode == M_NORM || mode == M_AUTO)) begin
          state_nxt = S_PRE;
          start     = 1'b1;
        end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign done_set = (state == S_POST) && (state_nxt == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      dec_cnt      <= '0;
      addr         <= '0;
      smpl_cnt     <= '0;
      trig_cnt     <= '0;
      auto_cnt     <= '0;
      armed        <= 1'b0;
      auto_trig    <= 1'b0;
      capture_done <= 1'b0;
      trace_end    <= '0;
    end else begin
      state     <= state_nxt;
      auto_trig <= auto_fire;
      armed     <= (state_nxt == S_ARMED) || (state_nxt == S_POST);

      if (start || keep)   dec_cnt <= '0;
      else if (smpl_tick)  dec_cnt <= dec_cnt + DCW'(1);

      if (start)   addr <= '0;
      else if (wr) addr <= addr + ADDR_W'(1);

      if (start)                          smpl_cnt <= '0;
      else if (wr && state == S_PRE)      smpl_cnt <= smpl_cnt + ADDR_W'(1);

      if (start)                          trig_cnt <= '0;
      else if (wr && state == S_POST)     trig_cnt <= trig_cnt + ADDR_W'(1);

      if (start)                                          auto_cnt <= '0;
      else if (wr && state == S_ARMED && mode == M_AUTO)  auto_cnt <= auto_cnt + AW'(1);

      // Completion outranks a coincident clear from the readout side.
      if (done_set)              capture_done <= 1'b1;
      else if (clr_capture_done) capture_done <= 1'b0;

      if (done_set) trace_end <= addr;
    end
  end

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// Self-checking bench for dso_capture_ctrl: directed corner sequences, a vector table for
// decimation, and randomized captures scored against a write-count reference model.
module tb_dso_capture_ctrl;

  localparam int ADDR_W  = 9;
  localparam int DEC_W   = 4;
  localparam int NCH     = 3;
  localparam int AUTO_TO = 64;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              smpl_tick = 1'b0;
  logic              run = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [ADDR_W-1:0] trig_pos = '0;
  logic [DEC_W-1:0]  decimator = '0;
  logic [NCH-1:0]    ch_en = '0;
  logic              triggered = 1'b0;
  logic              clr_capture_done = 1'b0;
  logic [NCH-1:0]    we;
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic              trig_en;
  logic              armed;
  logic              auto_trig;
  logic              capture_done;
  logic [ADDR_W-1:0] trace_end;
  logic              busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [NCH-1:0]    s_we;
  logic              s_en, s_trig_en, s_busy;
  logic [ADDR_W-1:0] s_addr;

  typedef struct {
    logic              tick;
    logic              trig;
    logic [NCH-1:0]    exp_we;
    logic              exp_en;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_trig_en;
  } vec_t;

  vec_t vecs[10];

  dso_capture_ctrl #(
    .ADDR_W(ADDR_W), .DEC_W(DEC_W), .NCH(NCH), .AUTO_TO(AUTO_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .smpl_tick(smpl_tick), .run(run), .mode(mode),
    .trig_pos(trig_pos), .decimator(decimator), .ch_en(ch_en), .triggered(triggered),
    .clr_capture_done(clr_capture_done), .we(we), .en(en), .addr(addr), .trig_en(trig_en),
    .armed(armed), .auto_trig(auto_trig), .capture_done(capture_done),
    .trace_end(trace_end), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: inputs held for the cycle, combinational outputs sampled mid-cycle,
  // registered outputs readable on return (just after the edge).
  task automatic cyc(input logic t, input logic tr, input logic c);
    smpl_tick = t;
    triggered = tr;
    clr_capture_done = c;
    @(negedge clk);
    s_we = we; s_en = en; s_trig_en = trig_en; s_busy = busy; s_addr = addr;
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] m);
    run  = 1'b1;
    mode = m;
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic to_idle();
    run = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic random_run(input int r);
    int dec, tp, tpe, m, ticks, n, a_pt, tpt, exp_end, after, fails0;
    bit t, tr, keep, wr, in_armed, in_post, done, auto_exp;
    dec  = $urandom_range(0, 1);
    tp   = (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(0, 255);
    tpe  = (tp == 0) ? 1 : tp;
    m    = $urandom_range(1, 2);
    decimator = DEC_W'(dec);
    trig_pos  = ADDR_W'(tp);
    ch_en     = NCH'($urandom_range(1, 7));
    ticks = 0; n = 0; tpt = -1; exp_end = 0; after = 0; done = 0;
    a_pt   = DEPTH - tpe;
    fails0 = n_fail;
    start(2'(m));
    for (int c = 0; c < 20000; c++) begin
      t  = ($urandom_range(0, 3) != 0);
      tr = ($urandom_range(0, 63) == 0);
      keep = 1'b0;
      if (t) begin
        ticks++;
        keep = ((ticks % (1 << dec)) == 0);
      end
      wr       = keep && !done;
      in_armed = !done && (n >= a_pt) && (tpt < 0);
      in_post  = !done && (tpt >= 0);
      cyc(t, tr, 1'b0);
      check($sformatf("rand%0d_en", r), 32'(s_en), 32'(wr));
      check($sformatf("rand%0d_we", r), 32'(s_we), 32'(wr ? ch_en : '0));
      check($sformatf("rand%0d_trig_en", r), 32'(s_trig_en), 32'(in_armed));
      auto_exp = 1'b0;
      if (wr) n++;
      if (in_armed) begin
        if (tr) tpt = n;
        else if (m == 2 && wr && (n - a_pt) == AUTO_TO) begin
          tpt = n;
          auto_exp = 1'b1;
        end
      end else if (in_post && wr && (n - tpt) == tpe) begin
        done = 1'b1;
        exp_end = (n - 1) % DEPTH;
      end
      check($sformatf("rand%0d_auto_trig", r), 32'(auto_trig), 32'(auto_exp));
      check($sformatf("rand%0d_armed", r), 32'(armed), 32'(!done && n >= a_pt));
      check($sformatf("rand%0d_done", r), 32'(capture_done), 32'(done));
      check($sformatf("rand%0d_addr", r), 32'(addr), 32'(n % DEPTH));
      if (done) begin
        check($sformatf("rand%0d_trace_end", r), 32'(trace_end), 32'(exp_end));
        after++;
      end
      if (after >= 4 || n_fail != fails0) break;
    end
    check($sformatf("rand%0d_completed", r), 32'(done), 32'(1));
    to_idle();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 3'b000, 1'b0, 9'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 3'b000, 1'b0, 9'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 3'b000, 1'b0, 9'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 3'b000, 1'b0, 9'd0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 3'b101, 1'b1, 9'd1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 3'b000, 1'b0, 9'd1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 3'b000, 1'b0, 9'd1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 3'b000, 1'b0, 9'd1, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 3'b101, 1'b1, 9'd2, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 3'b000, 1'b0, 9'd2, 1'b0};

    // Reset state
    #3;
    check("rst_we", 32'(we), 0);
    check("rst_en", 32'(en), 0);
    check("rst_addr", 32'(addr), 0);
    check("rst_flags", 32'({trig_en, armed, auto_trig, capture_done, busy}), 0);
    check("rst_trace_end", 32'(trace_end), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decimation by 4 with channel 1 masked; triggers in PRE ignored
    decimator = DEC_W'(2);
    ch_en     = 3'b101;
    trig_pos  = ADDR_W'(100);
    start(2'b01);
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].tick, vecs[i].trig, 1'b0);
      check($sformatf("dec_we[%0d]", i), 32'(s_we), 32'(vecs[i].exp_we));
      check($sformatf("dec_en[%0d]", i), 32'(s_en), 32'(vecs[i].exp_en));
      check($sformatf("dec_addr[%0d]", i), 32'(addr), 32'(vecs[i].exp_addr));
      check($sformatf("dec_trig_en[%0d]", i), 32'(s_trig_en), 32'(vecs[i].exp_trig_en));
    end
    to_idle();

    // Normal mode: arm after 412, trigger at 500, done after 600, clear coincident
    begin
      int nw;
      nw = 0;
      decimator = '0;
      ch_en     = 3'b111;
      trig_pos  = ADDR_W'(100);
      start(2'b01);
      for (int k = 1; k <= 600; k++) begin
        cyc(1'b1, (k == 100 || k == 412 || k == 500), (k == 600));
        if (s_en) nw++;
        if (k == 411) check("norm_armed_411", 32'(armed), 0);
        if (k == 412) check("norm_armed_412", 32'(armed), 1);
        if (k == 412) check("norm_trig_en_pre", 32'(s_trig_en), 0);
        if (k == 500) check("norm_trig_en_armed", 32'(s_trig_en), 1);
        if (k == 511) check("norm_addr_511", 32'(addr), 511);
        if (k == 512) check("norm_addr_wrap", 32'(addr), 0);
        if (k == 599) check("norm_done_599", 32'(capture_done), 0);
      end
      check("norm_writes", nw, 600);
      check("norm_done_set_wins", 32'(capture_done), 1);
      check("norm_trace_end", 32'(trace_end), 87);
      check("norm_armed_clr", 32'(armed), 0);
      check("norm_busy", 32'(busy), 0);
      cyc(1'b1, 1'b0, 1'b0);
      check("norm_done_no_write", 32'(s_en), 0);
      to_idle();
    end

    // Auto mode: forced trigger after 412+64 writes
    trig_pos = ADDR_W'(100);
    start(2'b10);
    for (int k = 1; k <= 576; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (k == 475) check("auto_pulse_475", 32'(auto_trig), 0);
      if (k == 476) check("auto_pulse_476", 32'(auto_trig), 1);
      if (k == 477) check("auto_pulse_477", 32'(auto_trig), 0);
      if (k == 575) check("auto_done_575", 32'(capture_done), 0);
    end
    check("auto_done", 32'(capture_done), 1);
    check("auto_trace_end", 32'(trace_end), 63);
    to_idle();

    // Single-shot: hold in DONE after clear, restart only through IDLE
    trig_pos = ADDR_W'(10);
    ch_en    = 3'b011;
    start(2'b11);
    for (int k = 1; k <= 515; k++) begin
      cyc(1'b1, (k == 505), 1'b0);
      if (k == 514) check("ss_done_514", 32'(capture_done), 0);
    end
    check("ss_done", 32'(capture_done), 1);
    check("ss_trace_end", 32'(trace_end), 2);
    cyc(1'b1, 1'b0, 1'b1);
    check("ss_clr_no_write", 32'(s_en), 0);
    check("ss_clr", 32'(capture_done), 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      check($sformatf("ss_hold_en[%0d]", k), 32'(s_en), 0);
    end
    run = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    start(2'b11);
    cyc(1'b1, 1'b0, 1'b0);
    check("ss_restart_en", 32'(s_en), 1);
    check("ss_restart_addr", 32'(s_addr), 0);
    check("ss_restart_we", 32'(s_we), 32'(3'b011));

    // Abort mid-POST
    for (int k = 2; k <= 507; k++) cyc(1'b1, (k == 505), 1'b0);
    check("abort_pre_busy", 32'(busy), 1);
    run = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    check("abort_en", 32'(s_en), 0);
    check("abort_we", 32'(s_we), 0);
    check("abort_armed", 32'(armed), 0);
    check("abort_busy", 32'(busy), 0);

    // Reset mid-POST with a stale completed trace still flagged
    ch_en = 3'b111;
    start(2'b01);
    for (int k = 1; k <= 515; k++) cyc(1'b1, (k == 505), 1'b0);
    check("rp_done", 32'(capture_done), 1);
    run = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    check("rp_idle_keeps_done", 32'(capture_done), 1);
    start(2'b01);
    for (int k = 1; k <= 505; k++) cyc(1'b1, (k == 503), 1'b0);
    check("rp_in_post", 32'({busy, armed, capture_done}), 32'(3'b111));
    #2;
    rst_n = 1'b0;
    #1;
    check("rp_we", 32'(we), 0);
    check("rp_en", 32'(en), 0);
    check("rp_addr", 32'(addr), 0);
    check("rp_flags", 32'({trig_en, armed, auto_trig, capture_done, busy}), 0);
    check("rp_trace_end", 32'(trace_end), 0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int r = 0; r < 8; r++) random_run(r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
